accelerator_vector_integration_feeder: RTL

Upstream stage of the vector integration accelerator. Captures a vector of float samples element by element into a local buffer. On START, it launches the integrator with the latched size, period and length, then replays the samples one per downstream request. It holds off reporting READY until the integrator signals completion.

---
 rtl/accelerator_vector_pkg.sv | 23 ++
 rtl/accelerator_vector_integration_feeder_buffer.sv | 25 ++
 rtl/accelerator_vector_integration_feeder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/accelerator_vector_pkg.sv
// Shared types and constants for the vector integration feeder and its buffer.
package accelerator_vector_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        STREAM,
        WAIT_DONE
    } feeder_state_t;

    localparam int CONTROL_W = 4;
    localparam int DATA_W    = 64;

    localparam logic [CONTROL_W-1:0] ZERO_CONTROL = '0;
    localparam logic [CONTROL_W-1:0] ONE_CONTROL  = CONTROL_W'(1);
    localparam logic [DATA_W-1:0]    ZERO_DATA    = '0;
    localparam logic [DATA_W-1:0]    ONE_DATA     = DATA_W'(1);

    // Occupancy values that define the EMPTY and FULL flags for the default depth.
    localparam int COUNT_EMPTY = 0;
    localparam int COUNT_FULL  = 16;

endpackage

// File: rtl/accelerator_vector_integration_feeder_buffer.sv
// Sample store: synchronous write, registered read, no reset so it maps onto block RAM.
module accelerator_vector_buffer #(
    parameter int DATA_SIZE    = 64,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    CLK,
    input  logic                    write_enable,
    input  logic [ADDRESS_SIZE-1:0] write_address,
    input  logic [DATA_SIZE-1:0]    write_data,
    input  logic [ADDRESS_SIZE-1:0] read_address,
    output logic [DATA_SIZE-1:0]    read_data
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
        read_data <= mem[read_address];
    end

endmodule

// File: rtl/accelerator_vector_integration_feeder.sv
// Buffers a vector of samples, then launches the integrator and replays the samples on request.
module accelerator_vector_integration_feeder
    import accelerator_vector_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 LOAD_ENABLE,
    input  logic                 DATA_REQUEST,
    input  logic                 DOWNSTREAM_READY,
    output logic                 START_OUT,
    output logic                 DATA_OUT_VECTOR_ENABLE,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 OVERFLOW,
    input  logic [DATA_SIZE-1:0] PERIOD_IN,
    input  logic [DATA_SIZE-1:0] LENGTH_IN,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic [DATA_SIZE-1:0] SIZE_OUT,
    output logic [DATA_SIZE-1:0] PERIOD_OUT,
    output logic [DATA_SIZE-1:0] LENGTH_OUT,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    // Counters must hold DEPTH itself, not just DEPTH-1.
    localparam int CNT_W = (CONTROL_SIZE > ADDRESS_SIZE) ? CONTROL_SIZE : ADDRESS_SIZE + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
    localparam cnt_t ZERO_CNT  = cnt_t'(ZERO_CONTROL);
    localparam cnt_t ONE_CNT   = cnt_t'(ONE_CONTROL);

    feeder_state_t state_reg, state_next;
    logic [ADDRESS_SIZE-1:0] wr_ptr_reg, wr_ptr_next;
    cnt_t rd_ptr_reg, rd_ptr_next;
    cnt_t count_reg, count_next;
    cnt_t size_reg, size_next;
    logic [DATA_SIZE-1:0] period_reg, period_next;
    logic [DATA_SIZE-1:0] length_reg, length_next;
    logic [DATA_SIZE-1:0] data_out_reg, data_out_next;
    logic strobe_reg, strobe_next;
    logic start_out_reg, start_out_next;
    logic ready_reg, ready_next;
    logic overflow_reg, overflow_next;
    logic done_seen_reg, done_seen_next;
    logic full_reg, empty_reg;
    logic bypass_valid_reg;
    logic [DATA_SIZE-1:0] bypass_data_reg;

    logic buf_we;
    logic accept_write;
    logic [ADDRESS_SIZE-1:0] read_addr;
    logic [DATA_SIZE-1:0] read_data;
    logic [DATA_SIZE-1:0] fetched;

    // Address the next pointer so the RAM output already holds buffer[rd_ptr_reg].
    assign read_addr = rd_ptr_next[ADDRESS_SIZE-1:0];
    assign fetched   = bypass_valid_reg ? bypass_data_reg : read_data;

    accelerator_vector_buffer #(
        .DATA_SIZE    (DATA_SIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_buffer (
        .CLK           (CLK),
        .write_enable  (buf_we),
        .write_address (wr_ptr_reg),
        .write_data    (DATA_IN),
        .read_address  (read_addr),
        .read_data     (read_data)
    );

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        size_next      = size_reg;
        period_next    = period_reg;
        length_next    = length_reg;
        data_out_next  = data_out_reg;
        overflow_next  = overflow_reg;
        done_seen_next = done_seen_reg;
        strobe_next    = 1'b0;
        start_out_next = 1'b0;
        ready_next     = 1'b0;
        buf_we         = 1'b0;

        accept_write = LOAD_ENABLE && (state_reg == IDLE) && (count_reg != DEPTH_CNT);
        if (LOAD_ENABLE && !accept_write) begin
            overflow_next = 1'b1;
        end
        if (accept_write) begin
            buf_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            count_next  = count_reg + ONE_CNT;
        end

        case (state_reg)
            IDLE: begin
                if (START) begin
                    if (count_next == cnt_t'(COUNT_EMPTY)) begin
                        ready_next = 1'b1;
                    end else begin
                        period_next    = PERIOD_IN;
                        length_next    = LENGTH_IN;
                        size_next      = count_next;
                        // Element 0 may be the word being written in this very cycle.
                        data_out_next  = (buf_we && wr_ptr_reg == '0) ? DATA_IN : fetched;
                        strobe_next    = 1'b1;
                        start_out_next = 1'b1;
                        rd_ptr_next    = ONE_CNT;
                        done_seen_next = 1'b0;
                        state_next     = LAUNCH;
                    end
                end
            end
            LAUNCH, STREAM: begin
                if (DOWNSTREAM_READY) begin
                    done_seen_next = 1'b1;
                end
                if (DATA_REQUEST && (rd_ptr_reg < size_reg)) begin
                    data_out_next = fetched;
                    strobe_next   = 1'b1;
                    rd_ptr_next   = rd_ptr_reg + ONE_CNT;
                end
                state_next = (rd_ptr_next == size_reg) ? WAIT_DONE : STREAM;
            end
            WAIT_DONE: begin
                if (DOWNSTREAM_READY || done_seen_reg) begin
                    ready_next     = 1'b1;
                    count_next     = ZERO_CNT;
                    wr_ptr_next    = '0;
                    rd_ptr_next    = ZERO_CNT;
                    done_seen_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg        <= IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= ZERO_CNT;
            count_reg        <= ZERO_CNT;
            size_reg         <= ZERO_CNT;
            period_reg       <= DATA_SIZE'(ZERO_DATA);
            length_reg       <= DATA_SIZE'(ZERO_DATA);
            data_out_reg     <= DATA_SIZE'(ZERO_DATA);
            strobe_reg       <= 1'b0;
            start_out_reg    <= 1'b0;
            ready_reg        <= 1'b0;
            overflow_reg     <= 1'b0;
            done_seen_reg    <= 1'b0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            bypass_valid_reg <= 1'b0;
            bypass_data_reg  <= DATA_SIZE'(ZERO_DATA);
        end else begin
            state_reg        <= state_next;
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            size_reg         <= size_next;
            period_reg       <= period_next;
            length_reg       <= length_next;
            data_out_reg     <= data_out_next;
            strobe_reg       <= strobe_next;
            start_out_reg    <= start_out_next;
            ready_reg        <= ready_next;
            overflow_reg     <= overflow_next;
            done_seen_reg    <= done_seen_next;
            full_reg         <= (count_next == DEPTH_CNT);
            empty_reg        <= (count_next == cnt_t'(COUNT_EMPTY));
            // The RAM returns old data on a same-address read/write, so remember the new word.
            bypass_valid_reg <= buf_we && (wr_ptr_reg == read_addr);
            bypass_data_reg  <= DATA_IN;
        end
    end

    assign READY                  = ready_reg;
    assign START_OUT              = start_out_reg;
    assign DATA_OUT_VECTOR_ENABLE = strobe_reg;
    assign FULL                   = full_reg;
    assign EMPTY                  = empty_reg;
    assign OVERFLOW               = overflow_reg;
    assign SIZE_OUT               = DATA_SIZE'(size_reg);
    assign PERIOD_OUT             = period_reg;
    assign LENGTH_OUT             = length_reg;
    assign DATA_OUT               = data_out_reg;

endmodule
